// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_EARLY_OUT_EN to bypass the iteration loop for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            reg_write
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    localparam logic [5:0] LastIter = 6'(XLEN - 1);

    state_e            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [4:0]        rd_q, rd_d, rd_out_q, rd_out_d;
    logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic              div0_q, div0_d, ovf_q, ovf_d;

    logic            is_div_in, a_signed, b_signed, in_neg_a, in_neg_b;
    logic            div0_in, ovf_in, early_in;
    logic [XLEN-1:0] mag_a, mag_b, int_min;

    assign int_min   = {1'b1, {(XLEN-1){1'b0}}};
    assign is_div_in = funct3[2];
    assign a_signed  = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b110);
    assign b_signed  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign in_neg_a  = a_signed && op_a[XLEN-1];
    assign in_neg_b  = b_signed && op_b[XLEN-1];
    assign mag_a     = in_neg_a ? -op_a : op_a;
    assign mag_b     = in_neg_b ? -op_b : op_b;
    assign div0_in   = is_div_in && (op_b == '0);
    assign ovf_in    = is_div_in && !funct3[0] && (op_a == int_min) && (op_b == '1);

`ifdef MULDIV_EARLY_OUT_EN
    assign early_in = div0_in || ovf_in;
`else
    assign early_in = 1'b0;
`endif

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    always_comb begin
        prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quo  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (div0_q) begin
            quo = '1;
            rem = a_q;
        end else if (ovf_q) begin
            quo = int_min;
            rem = '0;
        end
        case (f3_q)
            3'b000:                 fix_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo;
            default:                fix_res = rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        a_d      = a_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    f3_d    = funct3;
                    a_d     = op_a;
                    rd_d    = rd_in;
                    neg_a_d = in_neg_a;
                    neg_b_d = in_neg_b;
                    div0_d  = div0_in;
                    ovf_d   = ovf_in;
                    opnd_d  = is_div_in ? mag_b : mag_a;
                    acc_d   = {{XLEN{1'b0}}, is_div_in ? mag_a : mag_b};
                    cnt_d   = '0;
                    state_d = early_in ? StFix : StCalc;
                end
            end
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = f3_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LastIter) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    result_d = fix_res;
                    rd_out_d = rd_q;
                    state_d  = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            f3_q     <= '0;
            a_q      <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            a_q      <= a_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    // A flush arriving in DONE suppresses the write as well
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone) && !flush;
    assign reg_write = done && (rd_out_q != '0);
    assign result    = result_q;
    assign rd_out    = rd_out_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand/result width; all values below assume 32.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port flush  input  1  synchronous abort of an in-flight operation.
REQ-006 SHALL have port funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port op_a  input  XLEN  rs1 operand from register-file read_data_1.
REQ-008 SHALL have port op_b  input  XLEN  rs2 operand from register-file read_data_2.
REQ-009 SHALL have port rd_in  input  5  destination register index.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port result  output  XLEN  result for the register-file write_data port.
REQ-013 SHALL have port rd_out  output  5  destination index for the register-file rd port.
REQ-014 SHALL have port reg_write  output  1  register-file write enable.

Function
REQ-015 SHALL implement the FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
REQ-016 SHALL leave IDLE only on start=1; on that edge it SHALL latch funct3, op_a, op_b and rd_in, load the operand magnitudes, and clear a 6-bit iteration counter.
REQ-017 SHALL perform one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per CALC cycle, taking 32 iterations, then enter FIX.
REQ-018 SHALL in FIX apply sign correction (two's-complement negate where signs require) and select the high/low product half or the quotient/remainder.
REQ-019 SHALL in DONE assert done=1 for exactly one cycle, drive result and rd_out, and assert reg_write=1 unless rd_out==0.
REQ-020 SHALL give a default latency where done is high in the cycle after the 33rd rising edge following the start-sampling edge.
REQ-021 SHALL hold result and rd_out stable from DONE until the next DONE.
REQ-022 SHALL ignore start while busy=1; operand changes while busy SHALL have no effect.
REQ-023 SHALL compute MULH/MULHSU/MULHU as the upper 32 bits of the 64-bit signed*signed, signed*unsigned and unsigned*unsigned products; MUL SHALL give the lower 32 bits.
REQ-024 SHALL, for division by zero, return quotient 0xFFFFFFFF and remainder = op_a for both the signed and unsigned forms.
REQ-025 SHALL, for signed overflow (0x80000000 / 0xFFFFFFFF), return quotient 0x80000000 and remainder 0.
REQ-026 SHALL truncate signed quotients toward zero, with the remainder taking the dividend's sign.
REQ-027 SHALL, when flush=1 in any non-IDLE state, enter IDLE on the next edge with no done/reg_write pulse; flush SHALL take priority over state progression.
REQ-028 SHALL treat flush=1 and start=1 together in IDLE as start ignored.

Reset
REQ-029 SHALL, on rst_n=0 at any time including mid-operation, force IDLE immediately and clear busy, done, reg_write, result, rd_out and the counter to 0.
REQ-030 SHALL discard an in-flight operation on reset and never complete it after rst_n returns high.

Configuration
REQ-031 SHALL, with MULDIV_EARLY_OUT_EN defined, detect divide-by-zero and signed overflow at start and go IDLE -> FIX -> DONE, with done high after the 2nd edge following start and results per REQ-024/025.
REQ-032 SHALL, without MULDIV_EARLY_OUT_EN, use the full 33-edge latency for all operations with identical results.

Verification
REQ-033 SHALL cover: MUL op_a=7, op_b=0xFFFFFFFD, rd_in=5 -> result 0xFFFFFFEB, rd_out=5, reg_write=1, done exactly 33 edges after start.
REQ-034 SHALL cover: MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH of the same operands -> 0x00000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-035 SHALL cover: DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-036 SHALL cover: DIVU 10/0 -> 0xFFFFFFFF and REMU 10/0 -> 10; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0; latency 33 edges without the macro and 2 edges with it.
REQ-037 SHALL cover: rd_in=0 with MUL 3*4 -> result 12, done=1, reg_write=0.
REQ-038 SHALL cover: start, then a second start at CALC cycle 5 (ignored), flush at cycle 10 (busy=0 next edge, no done), and rst_n=0 at cycle 20 of a fresh op (all outputs 0, no done after release).
